inst_fetch: RTL and testbench

- Instruction fetch unit: producer of the 32-bit instruction word consumed by the instruction decoder.
- Fetches little-endian instruction bytes through a byte-wide, request/grant memory port shared with the load/store path.
- Assembles each 32-bit word and buffers {pc, inst} pairs in a small FIFO, presented to the decode stage with valid/ready.
- Supports redirect (branch/jump resolution) with a full flush.

---
 rtl/inst_fetch_pkg.sv | 26 ++
 rtl/inst_fetch_if.sv | 38 +++
 rtl/inst_fetch_queue.sv | 63 ++++++
 rtl/inst_fetch.sv | 125 ++++++++++++
 tb/tb_inst_fetch.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// ============================================================================
// inst_fetch_pkg : shared widths, reset pc and types for the fetch unit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_fetch_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int BYTE_WIDTH = 8;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_if.sv
// ============================================================================
// inst_fetch_if : memory port, redirect and decode handshake of the fetch unit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_fetch_if;

  logic                                   mem_req;
  logic [inst_fetch_pkg::ADDR_WIDTH-1:0]  mem_addr;
  logic                                   mem_grant;
  logic [inst_fetch_pkg::BYTE_WIDTH-1:0]  mem_din;
  logic                                   redirect_valid;
  logic [inst_fetch_pkg::ADDR_WIDTH-1:0]  redirect_pc;
  logic                                   inst_valid;
  logic [inst_fetch_pkg::DATA_WIDTH-1:0]  inst_out;
  logic [inst_fetch_pkg::ADDR_WIDTH-1:0]  inst_pc;
  logic                                   inst_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_grant, mem_din,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_out, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_grant, mem_din,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_out, inst_pc,
    output inst_ready
  );

endinterface

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// inst_queue : power-of-two FIFO of {pc, inst} with flush and occupancy count
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                   clk_i,
  input  wire logic                   rst_ni,
  input  wire logic                   en_i,
  input  wire logic                   flush_i,
  input  wire logic                   push_i,
  input  wire fetch_entry_t           push_data_i,
  input  wire logic                   pop_i,
  output fetch_entry_t                head_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  logic            w_do_push, w_do_pop;

  assign w_do_pop  = pop_i && (count_q != '0);
  assign w_do_push = push_i && (count_q != FULL_CNT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (en_i) begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (w_do_push && !w_do_pop)      count_q <= count_q + 1'b1;
        else if (w_do_pop && !w_do_push) count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk_i) begin
    if (en_i && !flush_i && w_do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// inst_fetch : byte-wide instruction fetch, word assembly and decode queue
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  wire logic       clk_in,
  input  wire logic       rst_in,
  input  wire logic       rdy_in,
  inst_fetch_if.master    bus
);

  localparam int              CW        = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(QUEUE_DEPTH);

  fetch_state_e                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]              pc_q, pc_d;
  logic [2:0]                         issue_cnt_q, issue_cnt_d;
  logic [1:0]                         recv_cnt_q, recv_cnt_d;
  logic [2:0][BYTE_WIDTH-1:0]         lanes_q, lanes_d;
  logic                               rx_pend_q, rx_pend_d;
  logic                               drop_next_q, drop_next_d;

  logic                               w_req, w_fire, w_rx, w_push, w_pop;
  logic [CW-1:0]                      w_count;
  fetch_entry_t                       w_entry, w_head;

  assign w_req  = (state_q == ST_FETCH) && (issue_cnt_q < 3'd4);
  assign w_fire = w_req && bus.mem_grant;
  // A byte arrives one cycle after each grant unless a redirect orphaned it.
  assign w_rx   = rx_pend_q && !drop_next_q;
  assign w_pop  = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
  assign w_entry = {pc_q, bus.mem_din, lanes_q};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    lanes_d     = lanes_q;
    rx_pend_d   = w_fire;
    drop_next_d = 1'b0;
    w_push      = 1'b0;
    if (bus.redirect_valid) begin
      state_d     = ST_IDLE;
      pc_d        = bus.redirect_pc;
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
      drop_next_d = w_fire;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (w_count < DEPTH_CNT) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (w_fire) issue_cnt_d = issue_cnt_q + 3'd1;
          if (w_rx) begin
            recv_cnt_d = recv_cnt_q + 2'd1;
            case (recv_cnt_q)
              2'd0:    lanes_d[0] = bus.mem_din;
              2'd1:    lanes_d[1] = bus.mem_din;
              2'd2:    lanes_d[2] = bus.mem_din;
              default: begin
                w_push      = 1'b1;
                pc_d        = pc_q + 32'd4;
                state_d     = ST_IDLE;
                issue_cnt_d = '0;
              end
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      lanes_q     <= '0;
      rx_pend_q   <= 1'b0;
      drop_next_q <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      lanes_q     <= lanes_d;
      rx_pend_q   <= rx_pend_d;
      drop_next_q <= drop_next_d;
    end
  end

  inst_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .en_i        (rdy_in),
    .flush_i     (bus.redirect_valid),
    .push_i      (w_push),
    .push_data_i (w_entry),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .count_o     (w_count)
  );

  assign bus.mem_req    = w_req;
  assign bus.mem_addr   = w_req ? (pc_q + {29'd0, issue_cnt_q}) : '0;
  assign bus.inst_valid = (w_count != '0);
  assign bus.inst_out   = w_head.inst;
  assign bus.inst_pc    = w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// tb_inst_fetch : self-checking bench for inst_fetch (vectors + random stream)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;

  inst_fetch_if bif ();

  inst_fetch #(
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .rdy_in (rdy),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_out, s_pc;
  logic        resp_v;
  logic [31:0] resp_a;
  logic [31:0] exp_issue, exp_pop;
  int          n_grants, n_pops;

  typedef struct {
    logic        g;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'hA0;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {mbyte(a + 32'd3), mbyte(a + 32'd2), mbyte(a + 32'd1), mbyte(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    s_req   = bif.mem_req;
    s_addr  = bif.mem_addr;
    s_valid = bif.inst_valid;
    s_out   = bif.inst_out;
    s_pc    = bif.inst_pc;
    if (!s_valid) begin
      chk("empty_inst", s_out, 32'h0);
      chk("empty_pc", s_pc, 32'h0);
    end
  endtask

  // Memory answers one active cycle after a grant; the stream model expects
  // consecutive byte addresses and consecutive words from the last restart.
  task automatic drive(input logic g, input logic r, input logic rd,
                       input logic rv, input logic [31:0] rp);
    bif.mem_din        = resp_v ? mbyte(resp_a) : 8'($urandom);
    bif.mem_grant      = g;
    rdy                = r;
    bif.inst_ready     = rd;
    bif.redirect_valid = rv;
    bif.redirect_pc    = rp;
    if (r) begin
      if (rv) begin
        exp_issue = rp;
        exp_pop   = rp;
      end else begin
        if (s_req && g) begin
          chk("issue_addr", s_addr, exp_issue);
          exp_issue = exp_issue + 32'd1;
          n_grants++;
        end
        if (s_valid && rd) begin
          chk("pop_pc", s_pc, exp_pop);
          chk("pop_inst", s_out, mword(exp_pop));
          exp_pop = exp_pop + 32'd4;
          n_pops++;
        end
      end
      resp_v = s_req && g;
      resp_a = s_addr;
    end
  endtask

  task automatic tick(input logic g, input logic rd);
    sample();
    drive(g, 1'b1, rd, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n              = 1'b0;
    rdy                = 1'b1;
    bif.mem_grant      = 1'b0;
    bif.inst_ready     = 1'b0;
    bif.redirect_valid = 1'b0;
    bif.redirect_pc    = 32'h0;
    @(negedge clk);
    rst_n     = 1'b1;
    resp_v    = 1'b0;
    exp_issue = 32'h0;
    exp_pop   = 32'h0;
    n_grants  = 0;
    n_pops    = 0;
  endtask

  vec_t vecs [11];
  int   first_req, first_val, base_pops, k;
  logic [31:0] rp;

  initial begin
    rst_n = 1'b1; rdy = 1'b1;
    bif.mem_grant = 1'b0; bif.mem_din = 8'h0; bif.inst_ready = 1'b0;
    bif.redirect_valid = 1'b0; bif.redirect_pc = 32'h0;
    resp_v = 1'b0; resp_a = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", {31'd0, bif.mem_req}, 32'd0);
    chk("rst_addr", bif.mem_addr, 32'd0);
    chk("rst_valid", {31'd0, bif.inst_valid}, 32'd0);
    chk("rst_inst", bif.inst_out, 32'd0);
    chk("rst_pc", bif.inst_pc, 32'd0);

    // Latency with continuous grant, then fill to capacity with no pops.
    do_reset();
    first_req = -1; first_val = -1;
    for (int i = 0; i < 50; i++) begin
      sample();
      if (s_req && first_req < 0) first_req = i;
      if (s_valid && first_val < 0) first_val = i;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    chk("first_req_cycle", first_req, 32'd0);
    chk("latency", first_val - first_req, 32'd5);
    chk("fill_grants", n_grants, 32'd16);
    chk("full_no_req", {31'd0, s_req}, 32'd0);
    chk("full_head_pc", s_pc, 32'h0);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b0);
    chk("refill_grants", n_grants, 32'd20);
    chk("refill_no_req", {31'd0, s_req}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      sample();
      if (!s_valid) break;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("drain_pops", n_pops, 32'd5);

    // Grant gaps: address held until granted, word assembled without repeats.
    vecs[0]  = '{1'b1, 1'b1, 32'd0, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'd1, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'd1, 1'b0, 32'h0, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 32'd1, 1'b0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 32'd2, 1'b0, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'd3, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 32'd3, 1'b0, 32'h0, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 32'd3, 1'b0, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'd0, 1'b0, 32'h0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 32'd0, 1'b1, 32'h00A00513, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'd4, 1'b1, 32'h00A00513, 32'h0};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      sample();
      chk($sformatf("vec%0d_req", i), {31'd0, s_req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req) chk($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, s_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_inst", i), s_out, vecs[i].exp_inst);
      chk($sformatf("vec%0d_pc", i), s_pc, vecs[i].exp_pc);
      drive(vecs[i].g, 1'b1, 1'b0, 1'b0, 32'h0);
    end

    // Redirect while byte 2 of the third word is granted, two entries queued.
    do_reset();
    k = 0;
    for (int i = 0; i < 80; i++) begin
      sample();
      if (s_req && s_addr == 32'h0A) begin
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
        k = 1;
        break;
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    chk("redir_reached", k, 32'd1);
    sample();
    chk("redir_valid_next", {31'd0, s_valid}, 32'd0);
    chk("redir_req_next", {31'd0, s_req}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    sample();
    chk("redir_resume_req", {31'd0, s_req}, 32'd1);
    chk("redir_resume_addr", s_addr, 32'h100);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 20 && n_pops == 0; i++) tick(1'b1, 1'b1);
    chk("redir_first_pop", n_pops, 32'd1);

    // Wrap past the top of memory, then pop exactly on a push at count=2.
    sample();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    base_pops = n_pops;
    k = 0;
    for (int i = 0; i < 80; i++) begin
      sample();
      if (resp_v && resp_a == 32'h7) begin
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        k = 1;
        break;
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    chk("wrap_reached", k, 32'd1);
    chk("wrap_pop", n_pops - base_pops, 32'd1);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      sample();
      if (!s_valid) break;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("wrap_total_pops", n_pops - base_pops, 32'd5);

    // Three-cycle global stall during a fetch.
    do_reset();
    k = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (s_req && s_addr == 32'h1) begin k = 1; break; end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    chk("stall_reached", k, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("stall_req", {31'd0, s_req}, 32'd1);
      chk("stall_addr", s_addr, 32'h1);
      drive(1'b1, (i == 2), 1'b0, 1'b0, 32'h0);
    end
    for (int i = 0; i < 20 && n_pops == 0; i++) tick(1'b1, 1'b1);
    chk("stall_pop", n_pops, 32'd1);

    // Asynchronous reset pulse mid-fetch with entries queued.
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
    sample();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, bif.mem_req}, 32'd0);
    chk("arst_addr", bif.mem_addr, 32'd0);
    chk("arst_valid", {31'd0, bif.inst_valid}, 32'd0);
    chk("arst_inst", bif.inst_out, 32'd0);
    chk("arst_pc", bif.inst_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; resp_v = 1'b0;
    exp_issue = 32'h0; exp_pop = 32'h0; n_pops = 0;
    for (int i = 0; i < 20 && n_pops == 0; i++) tick(1'b1, 1'b1);
    chk("arst_restart_pop", n_pops, 32'd1);

    // Randomised traffic against the stream model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic g, r, rd, rv;
      g  = ($urandom_range(0, 99) < 70);
      r  = ($urandom_range(0, 99) < 90);
      rd = ($urandom_range(0, 99) < 50);
      rv = r && ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 2))
        0:       rp = $urandom;
        1:       rp = 32'hFFFF_FFF8 + {28'd0, 4'($urandom_range(0, 1) * 4)};
        default: rp = {22'd0, 8'($urandom), 2'b00};
      endcase
      sample();
      drive(g, r, rd, rv, rp);
    end
    chk("random_progress", {31'd0, (n_pops > 100)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
